// File: rtl/home_event_scheduler_if.sv
// home_event_scheduler_if: sensor-side inputs and actuator-side outputs of the event scheduler
//   sens    sensor requests, bit k = channel k (channel 0 is fire)
//   temp    unsigned temperature reading
//   act     one-hot actuator drive for the sensor channels
//   cooler  temperature-channel cooling drive
//   heater  temperature-channel heating drive
//   display 0 = idle, k+1 = sensor channel k, N_SENSORS+1 = temperature
//   busy    high while a channel is being serviced
//   master: drives sens/temp; slave: the scheduler
interface home_event_scheduler_if #(
  parameter int N_SENSORS = 4,
  parameter int TEMP_W = 8
);
  localparam int DISP_W = $clog2(N_SENSORS + 2);
  logic [N_SENSORS-1:0] sens;
  logic [TEMP_W-1:0] temp;
  logic [N_SENSORS-1:0] act;
  logic cooler;
  logic heater;
  logic [DISP_W-1:0] display;
  logic busy;
  modport master (output sens, temp, input act, cooler, heater, display, busy);
  modport slave (input sens, temp, output act, cooler, heater, display, busy);
endinterface

// File: rtl/home_event_scheduler.sv
// home_event_scheduler: round-robin scheduler polling N_SENSORS sensor slots plus a temperature slot
//   clk  rising-edge clock
//   Rst  synchronous active-high reset
//   bus  home_event_scheduler_if.slave (sens/temp in; act/cooler/heater/display/busy out, all registered)
//   Optional build macro FIRE_PRIORITY_EN: sens[0] preempts any other slot, then scanning resumes
//   where it left off.
module home_event_scheduler #(
  parameter int N_SENSORS = 4,
  parameter int TEMP_W = 8,
  parameter int T_LOW = 50,
  parameter int T_HIGH = 70,
  parameter int HOLD_CYCLES = 4
) (
  input logic clk,
  input logic Rst,
  home_event_scheduler_if.slave bus
);
  localparam int DISP_W = $clog2(N_SENSORS + 2);
  localparam int CW = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [DISP_W-1:0] TS = DISP_W'(N_SENSORS);
  localparam logic [CW-1:0] C_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [TEMP_W-1:0] TL = TEMP_W'(T_LOW);
  localparam logic [TEMP_W-1:0] TH = TEMP_W'(T_HIGH);

  typedef enum logic {SCAN, SERVICE} state_t;

  state_t state, n_state;
  logic [DISP_W-1:0] ptr, n_ptr, cur, n_cur;
  logic [CW-1:0] cnt, n_cnt;
  logic heat, n_heat;
  logic cold, hot, svc;
  logic [N_SENSORS:0] req;
`ifdef FIRE_PRIORITY_EN
  // pre marks a pending or running preemptive slot-0 service; resume is where scanning continues after it
  logic [DISP_W-1:0] resume, n_resume;
  logic pre, n_pre;
`endif

  assign cold = bus.temp < TL;
  assign hot = bus.temp > TH;
  assign req = {cold | hot, bus.sens};

  function automatic logic [DISP_W-1:0] wrap(input logic [DISP_W-1:0] p);
    return p == TS ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    n_state = state;
    n_ptr = ptr;
    n_cnt = cnt;
    n_cur = cur;
    n_heat = heat;
`ifdef FIRE_PRIORITY_EN
    n_resume = resume;
    n_pre = pre;
`endif
    if (state == SCAN) begin
`ifdef FIRE_PRIORITY_EN
      if (pre || (bus.sens[0] && ptr != '0)) begin
        n_state = SERVICE;
        n_cur = '0;
        n_cnt = C_LAST;
        n_pre = 1'b1;
        if (!pre) n_resume = ptr;
      end else
`endif
      if (!(|req)) n_ptr = '0;
      else if (req[ptr]) begin
        n_state = SERVICE;
        n_cur = ptr;
        n_cnt = C_LAST;
        n_heat = cold;
      end else n_ptr = wrap(ptr);
    end else begin
`ifdef FIRE_PRIORITY_EN
      // abort cleans outputs this edge; the slot-0 service starts from SCAN on the next edge
      if (cur != '0 && bus.sens[0]) begin
        n_state = SCAN;
        n_ptr = '0;
        n_pre = 1'b1;
        n_resume = wrap(cur);
      end else
`endif
      if (cnt != '0) n_cnt = cnt - 1'b1;
      else begin
        n_state = SCAN;
        n_ptr = wrap(cur);
`ifdef FIRE_PRIORITY_EN
        if (pre) n_ptr = resume;
        n_pre = 1'b0;
`endif
      end
    end
  end

  // outputs are decoded from the next state so they register on the same edge as the state change
  assign svc = n_state == SERVICE;

  always_ff @(posedge clk) begin
    if (Rst) begin
      state <= SCAN;
      ptr <= '0;
      cnt <= '0;
      cur <= '0;
      heat <= 1'b0;
`ifdef FIRE_PRIORITY_EN
      resume <= '0;
      pre <= 1'b0;
`endif
      bus.act <= '0;
      bus.cooler <= 1'b0;
      bus.heater <= 1'b0;
      bus.display <= '0;
      bus.busy <= 1'b0;
    end else begin
      state <= n_state;
      ptr <= n_ptr;
      cnt <= n_cnt;
      cur <= n_cur;
      heat <= n_heat;
`ifdef FIRE_PRIORITY_EN
      resume <= n_resume;
      pre <= n_pre;
`endif
      bus.act <= (svc && n_cur != TS) ? N_SENSORS'(1) << n_cur : '0;
      bus.heater <= svc && n_cur == TS && n_heat;
      bus.cooler <= svc && n_cur == TS && !n_heat;
      bus.display <= svc ? n_cur + 1'b1 : '0;
      bus.busy <= svc;
    end
  end
endmodule

// File: tb/tb_home_event_scheduler.sv
// tb_home_event_scheduler: directed self-checking bench for home_event_scheduler (N=4, HOLD=4, 50..70 quiet)
module tb_home_event_scheduler;
  logic clk = 1'b0;
  logic Rst = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;
  logic [9:0] obs;
  localparam logic [9:0] HEAT = 10'b1_101_1_0_0000;
  localparam logic [9:0] COOL = 10'b1_101_0_1_0000;

  always #5 clk = ~clk;

  home_event_scheduler_if #(.N_SENSORS(4), .TEMP_W(8)) bus ();

  home_event_scheduler #(
    .N_SENSORS(4),
    .TEMP_W(8),
    .T_LOW(50),
    .T_HIGH(70),
    .HOLD_CYCLES(4)
  ) dut (
    .clk(clk),
    .Rst(Rst),
    .bus(bus)
  );

  assign obs = {bus.busy, bus.display, bus.heater, bus.cooler, bus.act};

  function automatic logic [9:0] a(input int k);
    return {1'b1, 3'(k + 1), 2'b00, 4'(1 << k)};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic rst_to(input logic [3:0] s, input logic [7:0] t);
    Rst = 1'b1;
    bus.sens = '0;
    bus.temp = 8'd60;
    repeat (2) @(negedge clk);
    check("reset outs", 32'(obs), 32'd0);
    Rst = 1'b0;
    bus.sens = s;
    bus.temp = t;
  endtask

  task automatic wait_busy(input string tag, input int lat);
    int w = 0;
    while (!bus.busy && w < 40) begin
      @(negedge clk);
      w++;
    end
    check({tag, " latency"}, 32'(w), 32'(lat));
  endtask

  task automatic svc(input string tag, input int lat, input logic [9:0] exp, input logic [7:0] ntemp);
    wait_busy(tag, lat);
    for (int i = 0; i < 4; i++) begin
      check({tag, " hold"}, 32'(obs), 32'(exp));
      if (i == 0) bus.temp = ntemp;
      @(negedge clk);
    end
    check({tag, " end"}, 32'(obs), 32'd0);
  endtask

  initial begin
    bus.sens = '0;
    bus.temp = 8'd60;
    @(negedge clk);
    rst_to(4'b0100, 8'd60);
    svc("first", 3, a(2), 8'd60);
    rst_to(4'b1011, 8'd60);
    svc("rr0", 1, a(0), 8'd60);
    svc("rr1", 1, a(1), 8'd60);
    svc("rr3", 2, a(3), 8'd60);
    svc("rr0b", 2, a(0), 8'd60);
    rst_to(4'b0000, 8'd40);
    svc("heat", 5, HEAT, 8'd40);
    bus.temp = 8'd71;
    svc("cool", 5, COOL, 8'd71);
    bus.temp = 8'd40;
    svc("heat flip", 5, HEAT, 8'd80);
    bus.temp = 8'd50;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("quiet 50", 32'(obs), 32'd0);
    end
    bus.temp = 8'd70;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("quiet 70", 32'(obs), 32'd0);
    end
    rst_to(4'b1000, 8'd60);
    repeat (2) @(negedge clk);
    bus.sens = '0;
    @(negedge clk);
    check("quiet return", 32'(obs), 32'd0);
    bus.sens = 4'b0010;
    svc("after quiet", 2, a(1), 8'd60);
    rst_to(4'b0001, 8'd60);
    wait_busy("mid", 1);
    @(negedge clk);
    check("mid hold2", 32'(obs), 32'(a(0)));
    Rst = 1'b1;
    @(negedge clk);
    check("mid reset", 32'(obs), 32'd0);
    Rst = 1'b0;
    bus.sens = 4'b0101;
    svc("restart", 1, a(0), 8'd60);
`ifdef FIRE_PRIORITY_EN
    rst_to(4'b0100, 8'd60);
    wait_busy("fire slot2", 3);
    check("fire slot2 on", 32'(obs), 32'(a(2)));
    bus.sens = 4'b0101;
    @(negedge clk);
    check("fire abort", 32'(obs), 32'd0);
    bus.sens = 4'b0000;
    svc("fire0", 1, a(0), 8'd60);
    bus.sens = 4'b1000;
    svc("resume3", 1, a(3), 8'd60);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/home_event_scheduler.md
# home_event_scheduler

Parametrised round-robin event scheduler for the home automation controller. It polls N_SENSORS binary sensor channels plus one temperature channel, and services each active request by driving its actuator for a fixed hold time. It reports the serviced channel on a display code. It is the configurable next generation of the fixed front-door/rear-door/fire/window/temperature sequencer and sits between the sensor input conditioning and the actuator drivers.

## Interface
- N_SENSORS, 4, number of binary sensor channels (≥1); channel 0 is the fire channel
- TEMP_W, 8, temperature word width
- T_LOW, 50, heater threshold; heater when temp < T_LOW
- T_HIGH, 70, cooler threshold; cooler when temp > T_HIGH (T_LOW ≤ T_HIGH)
- HOLD_CYCLES, 4, cycles an actuator stays asserted per service (≥1)
- DISP_W, $clog2(N_SENSORS+2), display code width (derived; do not override)

Ports:
- clk  in  1  clock; all logic on rising edge
- Rst  in  1  reset, synchronous, active-high
- sens  in  N_SENSORS  sensor requests; bit k = channel k
- temp  in  TEMP_W  unsigned temperature reading
- act  out  N_SENSORS  one-hot actuator drive; bit k services channel k
- cooler  out  1  temperature-channel cooling drive
- heater  out  1  temperature-channel heating drive
- display  out  DISP_W  0 = idle, k+1 = sensor channel k, N_SENSORS+1 = temperature
- busy  out  1  high while in SERVICE

## Operation
- Slots 0..N_SENSORS-1 are the sensors. Slot N_SENSORS (TS) is temperature.
- req[k] = sens[k]; req[TS] = (temp < T_LOW) | (temp > T_HIGH). Comparisons are unsigned at TEMP_W bits. T_LOW..T_HIGH inclusive is quiet.
- States: SCAN, SERVICE. Registers: ptr (slot index), cnt (hold counter), cur (serviced slot), resume (saved ptr, priority build only).
- Reset: state = SCAN, ptr = 0, cnt = 0. Outputs: act = 0, cooler = 0, heater = 0, display = 0, busy = 0.
- SCAN, no req anywhere: ptr ← 0, all outputs 0.
- SCAN, req[ptr] = 1: go to SERVICE with cur = ptr and cnt = HOLD_CYCLES-1. Assert the actuator for ptr, set display = ptr+1, busy = 1.
  - For TS, the actuator is heater if temp < T_LOW, otherwise cooler. The choice is latched at entry and held for the whole service.
- SCAN, req[ptr] = 0, some other req active: ptr ← ptr+1, wrapping from TS to 0. One slot is examined per cycle.
- SERVICE, cnt ≠ 0: cnt ← cnt-1, outputs held. A request that drops mid-service does not shorten the service.
- SERVICE, cnt = 0: go to SCAN with ptr ← cur+1 (wrapping from TS to 0). All outputs cleared on the same edge.
- Exactly one of act/cooler/heater is high at any time, or none.

## Timing
- Request seen at ptr in cycle t: outputs are high from edge t+1 for exactly HOLD_CYCLES cycles, then low for at least 1 cycle (SCAN).
- Worst-case latency from a request to service, without the priority build: (N_SENSORS+1)·(HOLD_CYCLES+1) cycles.
- All outputs are registered. There is no combinational path from inputs to outputs.
- Rst asserted mid-SERVICE: all outputs are 0 and ptr = 0 after the next edge. No partial-hold completion.

## Configuration
- FIRE_PRIORITY_EN defined:
  - sens[0] preempts everything.
  - In SCAN with ptr ≠ 0 and sens[0] = 1: resume ← ptr, then service slot 0.
  - In SERVICE of slot p ≠ 0 with sens[0] = 1: abort p (outputs cleared that edge), resume ← p+1 (wrapped), then service slot 0 starting the next edge with a full HOLD_CYCLES.
  - After a preemptive slot-0 service completes: ptr ← resume.
  - A continuous sens[0] starves the other channels. This is intended.
- FIRE_PRIORITY_EN undefined: strict round-robin. resume is not implemented and sens[0] is treated like any other channel.

## Test plan
- Reset: after Rst, all outputs 0. Assert sens = 4'b0100 with N_SENSORS=4, HOLD_CYCLES=4. act = 4'b0100 and display = 3 within 3 cycles of release, high for exactly 4 cycles, then act = 0.
- Round-robin: sens = 4'b1011 held, temp = 60. Service order is 0, 1, 3, 0, ...; each service is 4 cycles, with 1 SCAN cycle between adjacent services and one extra cycle per skipped slot.
- Temperature: temp = 40 gives heater = 1 and display = 5 for 4 cycles. temp = 71 gives cooler = 1. temp = 50 and temp = 70 give no service. temp changing 40→80 mid-service keeps heater until the service ends.
- Quiet return: while ptr = 2, drop all inputs. ptr = 0 and display = 0 next cycle. A new request on sens[1] is reached via slot 0 scan first.
- Reset mid-service: Rst in the 2nd hold cycle. All outputs 0 on the next edge, and restart servicing from slot 0.
- FIRE_PRIORITY_EN: during service of slot 2, pulse sens[0]. act[2] drops next edge, act[0] runs 4 cycles, then slot 3 is examined next.
